// File: rtl/mem_stage.sv
// Memory-access stage: launches one valid/ready bus transaction per load/store and formats store lanes and load data.
// Latency: at least 3 cycles per access (launch, BUSY until ready or timeout, DONE).
// Backpressure: stall_o holds the front of the pipeline from launch until DONE; a slow slave only lengthens BUSY.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] res_i,
    input  logic [31:0] sdata_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] res_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        err_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic          acc, is_w, is_h, launch, ready_hit, timeout_hit;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic [CW-1:0] cnt;
    logic [31:0]   wdata_fmt;
    logic [3:0]    wstrb_fmt;

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] o,
                                             input logic [2:0] f);
        logic [31:0] sh;
        sh = w >> {o, 3'b000};
        case (f)
            3'b000:  load_fmt = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_fmt = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_fmt = {24'b0, sh[7:0]};
            3'b101:  load_fmt = {16'b0, sh[15:0]};
            default: load_fmt = w;
        endcase
    endfunction

    assign acc         = valid_i & (memread_i | memwrite_i);
    assign is_w        = (funct3_i == 3'b010);
    assign is_h        = (funct3_i[1:0] == 2'b01);
    assign misalign_o  = acc & ((is_w & (|res_i[1:0])) | (is_h & res_i[0]));
    assign launch      = (state == IDLE) & acc & ~misalign_o;
    assign ready_hit   = (state == BUSY) & bus_ready_i;
    assign timeout_hit = (state == BUSY) & ~bus_ready_i & (cnt == CNT_LAST);
    assign res_o       = res_i;

    always_comb begin
        wdata_fmt = sdata_i;
        wstrb_fmt = 4'b1111;
        case (funct3_i)
            3'b000: begin
                wdata_fmt = {4{sdata_i[7:0]}};
                wstrb_fmt = 4'b0001 << res_i[1:0];
            end
            3'b001: begin
                wdata_fmt = {2{sdata_i[15:0]}};
                wstrb_fmt = res_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = BUSY;
            BUSY:    if (ready_hit || timeout_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by rst so the front of the pipeline is released while reset is held.
    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = launch & ~rst;
            BUSY:    stall_o = ~rst;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'b0;
            bus_wdata_o <= 32'b0;
            bus_wstrb_o <= 4'b0;
            ld_data_o   <= 32'b0;
            err_o       <= 1'b0;
            cnt         <= '0;
            off_q       <= 2'b0;
            f3_q        <= 3'b0;
        end else begin
            if (launch) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= memwrite_i;
                bus_addr_o  <= {res_i[31:2], 2'b00};
                bus_wdata_o <= wdata_fmt;
                bus_wstrb_o <= memwrite_i ? wstrb_fmt : 4'b0000;
                off_q       <= res_i[1:0];
                f3_q        <= funct3_i;
                err_o       <= 1'b0;
                cnt         <= '0;
            end
            if (ready_hit) begin
                bus_req_o <= 1'b0;
                ld_data_o <= load_fmt(bus_rdata_i, off_q, f3_q);
                err_o     <= 1'b0;
            end else if (timeout_hit) begin
                bus_req_o <= 1'b0;
                ld_data_o <= 32'b0;
                err_o     <= 1'b1;
            end else if (state == BUSY) begin
                cnt <= cnt + CW'(1);
            end
            if (state == DONE) cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, sign/zero loads, misalignment, timeout and asynchronous reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, memread_i, memwrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] res_i, sdata_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] ld_data_o, res_o;
    logic        stall_o, misalign_o, err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .funct3_i(funct3_i), .res_i(res_i), .sdata_i(sdata_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
        .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i),
        .ld_data_o(ld_data_o), .res_o(res_o), .stall_o(stall_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setin(input logic v, input logic rd, input logic wr, input logic [2:0] f,
                         input logic [31:0] r, input logic [31:0] s);
        valid_i = v; memread_i = rd; memwrite_i = wr; funct3_i = f; res_i = r; sdata_i = s;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        setin(0, 0, 0, 3'b000, 32'h0, 32'h0);
        bus_ready_i = 1'b0;
        bus_rdata_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, bus_req_o}, 32'h0);
        chk("rst_we", {31'b0, bus_we_o}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_wstrb", {28'b0, bus_wstrb_o}, 32'h0);
        chk("rst_ld", ld_data_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        rst = 1'b0;

        // Non-memory instruction with a stray ready
        setin(1, 0, 0, 3'b000, 32'hCAFEF00D, 32'h0);
        bus_ready_i = 1'b1;
        #1;
        chk("alu_res_o", res_o, 32'hCAFEF00D);
        chk("alu_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk);
        chk("alu_no_req", {31'b0, bus_req_o}, 32'h0);
        bus_ready_i = 1'b0;

        // SW 0x100, ready on the second BUSY cycle
        setin(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF);
        #1;
        chk("sw_launch_stall", {31'b0, stall_o}, 32'h1);
        @(negedge clk);
        chk("sw_req", {31'b0, bus_req_o}, 32'h1);
        chk("sw_we", {31'b0, bus_we_o}, 32'h1);
        chk("sw_addr", bus_addr_o, 32'h100);
        chk("sw_strb", {28'b0, bus_wstrb_o}, 32'hF);
        chk("sw_wdata", bus_wdata_o, 32'hDEADBEEF);
        chk("sw_busy1_stall", {31'b0, stall_o}, 32'h1);
        @(negedge clk);
        chk("sw_busy2_stall", {31'b0, stall_o}, 32'h1);
        chk("sw_busy2_req", {31'b0, bus_req_o}, 32'h1);
        bus_ready_i = 1'b1;
        @(negedge clk);
        chk("sw_done_stall", {31'b0, stall_o}, 32'h0);
        chk("sw_done_req", {31'b0, bus_req_o}, 32'h0);
        chk("sw_done_err", {31'b0, err_o}, 32'h0);
        bus_ready_i = 1'b0;
        @(posedge clk);
        #1 setin(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("sw_no_relaunch", {31'b0, bus_req_o}, 32'h0);
        chk("sw_idle_stall", {31'b0, stall_o}, 32'h0);

        // LB 0x203 then LBU 0x203, ready immediately
        setin(1, 1, 0, 3'b000, 32'h203, 32'h0);
        bus_rdata_i = 32'h80FF_1234;
        bus_ready_i = 1'b1;
        @(negedge clk);
        chk("lb_req", {31'b0, bus_req_o}, 32'h1);
        chk("lb_we", {31'b0, bus_we_o}, 32'h0);
        chk("lb_strb", {28'b0, bus_wstrb_o}, 32'h0);
        chk("lb_addr", bus_addr_o, 32'h200);
        @(negedge clk);
        chk("lb_ld", ld_data_o, 32'hFFFFFF80);
        chk("lb_done_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk);
        #1 setin(1, 1, 0, 3'b100, 32'h203, 32'h0);
        @(negedge clk);
        chk("lbu_launch_stall", {31'b0, stall_o}, 32'h1);
        chk("lbu_launch_req", {31'b0, bus_req_o}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("lbu_ld", ld_data_o, 32'h00000080);

        // SH 0x42
        @(posedge clk);
        #1 setin(1, 0, 1, 3'b001, 32'h42, 32'h0000ABCD);
        @(negedge clk);
        @(negedge clk);
        chk("sh_req", {31'b0, bus_req_o}, 32'h1);
        chk("sh_addr", bus_addr_o, 32'h40);
        chk("sh_strb", {28'b0, bus_wstrb_o}, 32'hC);
        chk("sh_wdata", bus_wdata_o, 32'hABCDABCD);
        @(negedge clk);

        // LW 0x101 is misaligned
        @(posedge clk);
        #1 setin(1, 1, 0, 3'b010, 32'h101, 32'h0);
        bus_ready_i = 1'b0;
        #1;
        chk("lw_mis_flag", {31'b0, misalign_o}, 32'h1);
        chk("lw_mis_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk);
        chk("lw_mis_req1", {31'b0, bus_req_o}, 32'h0);
        @(negedge clk);
        chk("lw_mis_req2", {31'b0, bus_req_o}, 32'h0);
        chk("lw_mis_stall2", {31'b0, stall_o}, 32'h0);

        // LH 0x102 is aligned
        setin(1, 1, 0, 3'b001, 32'h102, 32'h0);
        bus_rdata_i = 32'h8001_7F00;
        bus_ready_i = 1'b1;
        #1;
        chk("lh_mis_flag", {31'b0, misalign_o}, 32'h0);
        chk("lh_stall", {31'b0, stall_o}, 32'h1);
        @(negedge clk);
        chk("lh_req", {31'b0, bus_req_o}, 32'h1);
        chk("lh_addr", bus_addr_o, 32'h100);
        @(negedge clk);
        chk("lh_ld", ld_data_o, 32'hFFFF8001);

        // LW 0x10 with the slave silent
        @(posedge clk);
        #1 setin(1, 1, 0, 3'b010, 32'h10, 32'h0);
        bus_ready_i = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_req_o) n++;
            else if (n > 0) break;
        end
        chk("to_busy_cycles", n, 32'd16);
        chk("to_err", {31'b0, err_o}, 32'h1);
        chk("to_ld", ld_data_o, 32'h0);
        chk("to_done_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk);
        #1 setin(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("to_err_hold", {31'b0, err_o}, 32'h1);

        // Reset pulsed during BUSY, then a clean LW 0x0
        setin(1, 1, 0, 3'b010, 32'h20, 32'h0);
        @(negedge clk);
        chk("rb_req", {31'b0, bus_req_o}, 32'h1);
        chk("rb_err_cleared", {31'b0, err_o}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rb_async_req", {31'b0, bus_req_o}, 32'h0);
        chk("rb_async_stall", {31'b0, stall_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        setin(1, 1, 0, 3'b010, 32'h0, 32'h0);
        bus_rdata_i = 32'h12345678;
        bus_ready_i = 1'b1;
        #1;
        chk("post_rst_stall", {31'b0, stall_o}, 32'h1);
        @(negedge clk);
        chk("post_rst_req", {31'b0, bus_req_o}, 32'h1);
        chk("post_rst_addr", bus_addr_o, 32'h0);
        @(negedge clk);
        chk("post_rst_ld", ld_data_o, 32'h12345678);
        chk("post_rst_err", {31'b0, err_o}, 32'h0);
        @(posedge clk);
        #1 setin(0, 0, 0, 3'b000, 32'h0, 32'h0);
        bus_ready_i = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of EX; consumes the EX result (effective address), store data and load/store controls held in the EX/MEM register.
- Runs a valid/ready transaction on the data bus, formats store bytes/strobes and aligns/extends load data for write-back.
- Raises stall_o to freeze the front of the pipeline while a transaction is outstanding.
- Flags misaligned accesses and bus timeouts to the trap logic.

Parameters:
- TIMEOUT, 16: BUSY cycles without bus_ready_i before the transaction is aborted with err_o. Must be >= 1.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  EX/MEM register holds a live instruction
- memread_i  in  1  load
- memwrite_i  in  1  store
- funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- res_i  in  32  EX result; effective address for loads/stores
- sdata_i  in  32  store data, already forwarded
- bus_req_o  out  1  transaction request, registered
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word-aligned address ({res_i[31:2],2'b00})
- bus_wdata_o  out  32  lane-replicated store data
- bus_wstrb_o  out  4  byte enables; 4'b0000 for reads
- bus_ready_i  in  1  slave completes the transaction this cycle
- bus_rdata_i  in  32  read data, valid with bus_ready_i
- ld_data_o  out  32  aligned, extended load result
- res_o  out  32  res_i passthrough for ALU write-back
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- misalign_o  out  1  misaligned access detected; no transaction issued
- err_o  out  1  bus timeout on the completed access

Behaviour:
- Reset values:
  - State IDLE.
  - bus_req_o, bus_we_o, err_o = 0.
  - bus_addr_o, bus_wdata_o, ld_data_o, bus_wstrb_o = 0.
  - Timeout counter = 0.
- Access condition: acc = valid_i & (memread_i | memwrite_i).
- Misalignment (combinational):
  - misalign_o = acc & ((W & res_i[1:0] != 0) | (H/HU & res_i[0])).
  - A misaligned access issues no bus request, leaves the FSM in IDLE and keeps stall_o = 0.
- IDLE:
  - On acc & !misalign_o: stall_o = 1 combinationally.
  - Latch addr, we = memwrite_i, wdata, wstrb and res_i[1:0].
  - Drive bus_req_o = 1 from the next cycle; go to BUSY.
- BUSY:
  - bus_req_o = 1 and stall_o = 1; request fields held stable.
  - The counter increments each cycle.
  - bus_ready_i = 1: capture bus_rdata_i, err_o = 0, drop bus_req_o at the next edge, go to DONE.
  - Counter reaches TIMEOUT-1 without ready: drop bus_req_o, err_o = 1, ld_data_o = 0, go to DONE.
- DONE:
  - stall_o = 0 and ld_data_o valid; the pipeline advances at this edge.
  - Unconditionally return to IDLE, clear the counter, do not re-launch.
  - The same instruction is still on the inputs during DONE and must not start a second transaction.
  - err_o holds until the next access launches.
- Minimum latency: 3 cycles per access (launch, BUSY with ready, DONE).
- Store formatting:
  - B: wdata = {4{sdata[7:0]}}, strb = 4'b0001 << addr[1:0].
  - H: wdata = {2{sdata[15:0]}}, strb = addr[1] ? 4'b1100 : 4'b0011.
  - W: wdata = sdata, strb = 4'b1111.
- Load formatting:
  - Select the byte/half by the latched addr[1:0].
  - B/H: sign-extend. BU/HU: zero-extend. W: whole word.
  - Undefined funct3 loads as W.
- Non-memory instruction or valid_i = 0: res_o = res_i, stall_o = 0, no bus activity.
- Reset asserted mid-transaction: immediately IDLE, bus_req_o = 0; the slave must tolerate an abandoned request.
- bus_ready_i while not in BUSY is ignored.

Test Plan:
- SW, res_i=0x100, sdata=0xDEADBEEF, ready on the 2nd BUSY cycle:
  - Required: req=1, addr=0x100, strb=1111, wdata=0xDEADBEEF.
  - Required: stall_o high 3 cycles, DONE on cycle 4, no second request.
- LB, res_i=0x203, rdata=0x80FF_1234, ready immediately:
  - Required: ld_data_o=0xFFFFFF80.
  - Same with LBU: ld_data_o=0x00000080.
- SH, res_i=0x42, sdata=0x0000ABCD:
  - Required: addr=0x40, strb=1100, wdata=0xABCDABCD.
- LW, res_i=0x101:
  - Required: misalign_o=1, bus_req_o never asserts, stall_o=0.
  - LH at 0x102: misalign_o=0, normal access.
- LW with bus_ready_i tied 0, TIMEOUT=16:
  - Required: req drops after 16 BUSY cycles, err_o=1, ld_data_o=0, stall released in DONE.
- Reset pulsed during BUSY:
  - Required: bus_req_o=0 and stall_o=0 asynchronously.
  - A subsequent LW at 0x0 completes normally.
